// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
//
// Exception and interrupt commit controller for the commit stage. It feeds CP0
// and the fetch redirect path. It resolves the priority between synchronous
// exceptions, ERET and external interrupts. When it takes an event it issues a
// one-cycle flush and CP0 strobes. It then holds a redirect request to fetch
// until fetch accepts it over a valid/ready handshake.
//
// Optional build macro: EXC_TRAP_EN
//   When defined, this adds the `trap` input (ExcCode 0x0d). Its priority lies
//   between overflow and eret. When undefined, the port is absent and 0x0d is
//   never produced.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   commit_valid             an instruction is valid at commit this cycle
//   iaddr_err .. overflow    per-instruction exception causes
//   eret                     ERET at commit
//   in_delay_slot            the committing instruction sits in a delay slot
//   pc_address               committing PC
//   mem_address              data address of the faulting access
//   epc_address              current CP0 EPC (ERET target)
//   allow_interrupt          Status.IE & !Status.EXL
//   int_mask                 Status.IM
//   int_in                   asynchronous interrupt lines
//   redirect_ready           fetch accepts the redirect
//   exp_detect               one-cycle pipeline flush pulse
//   commit_stall             commit must hold
//   cp0_exp_en               CP0 exception write strobe
//   cp0_exl_clean            CP0 EXL clear strobe
//   cp0_exp_epc              EPC to write
//   cp0_exp_code             ExcCode
//   cp0_exp_bad_vaddr        BadVAddr value
//   cp0_exp_bad_vaddr_wen    BadVAddr write strobe
//   int_pending              Cause.IP view, before masking
//   redirect_valid/_pc       redirect request to fetch and its target
// -----------------------------------------------------------------------------
module exception_ctrl #(
   parameter int unsigned                 ADDR_W        = 32,
   parameter int unsigned                 INT_LINES     = 8,
   parameter logic [INT_LINES-1:0]        INT_EDGE_MASK = '0,
   parameter logic [ADDR_W-1:0]           EXC_VECTOR    = 32'hbfc00380
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  commit_valid,
   input  logic                  iaddr_err,
   input  logic                  daddr_err,
   input  logic                  mem_wen,
   input  logic                  invalid_inst,
   input  logic                  priv_inst,
   input  logic                  syscall,
   input  logic                  break_,
   input  logic                  eret,
   input  logic                  overflow,
`ifdef EXC_TRAP_EN
   input  logic                  trap,
`endif
   input  logic                  in_delay_slot,
   input  logic [ADDR_W-1:0]     pc_address,
   input  logic [ADDR_W-1:0]     mem_address,
   input  logic [ADDR_W-1:0]     epc_address,
   input  logic                  allow_interrupt,
   input  logic [INT_LINES-1:0]  int_mask,
   input  logic [INT_LINES-1:0]  int_in,
   input  logic                  redirect_ready,
   output logic                  exp_detect,
   output logic                  commit_stall,
   output logic                  cp0_exp_en,
   output logic                  cp0_exl_clean,
   output logic [ADDR_W-1:0]     cp0_exp_epc,
   output logic [4:0]            cp0_exp_code,
   output logic [ADDR_W-1:0]     cp0_exp_bad_vaddr,
   output logic                  cp0_exp_bad_vaddr_wen,
   output logic [INT_LINES-1:0]  int_pending,
   output logic                  redirect_valid,
   output logic [ADDR_W-1:0]     redirect_pc
);

   typedef enum logic [4:0] {
      EXC_INT  = 5'h00,
      EXC_ADEL = 5'h04,
      EXC_ADES = 5'h05,
      EXC_SYS  = 5'h08,
      EXC_BP   = 5'h09,
      EXC_RI   = 5'h0a,
      EXC_CPU  = 5'h0b,
      EXC_OV   = 5'h0c,
      EXC_TR   = 5'h0d
   } exc_code_e;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_REDIRECT = 1'b1
   } state_e;

   // ---------------------------------------------------------------------------
   // Interrupt synchronisation and pending latch
   // ---------------------------------------------------------------------------
   logic [INT_LINES-1:0] sync1_q, sync2_q, sync3_q;
   logic [INT_LINES-1:0] edge_pend_q, edge_pend_d;
   logic                 irq;
   logic                 irq_take;
   state_e               state_q;

   assign int_pending = (sync2_q & ~INT_EDGE_MASK) | (edge_pend_q & INT_EDGE_MASK);
   assign irq         = commit_valid & allow_interrupt & (|(int_pending & int_mask));
   assign irq_take    = irq & (state_q == S_IDLE);

   // Taking an interrupt clears every latched edge together. A rising edge
   // seen in the same cycle is OR-ed in afterwards, so that edge is not lost.
   assign edge_pend_d = ((edge_pend_q & ~{INT_LINES{irq_take}}) | (sync2_q & ~sync3_q))
                        & INT_EDGE_MASK;

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments. Every register
      // then samples pre-edge values, whatever order the statements are in.
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         sync3_q     <= '0;
         edge_pend_q <= '0;
      end else begin
         sync1_q     <= int_in;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         edge_pend_q <= edge_pend_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Cause priority decode
   // ---------------------------------------------------------------------------
   logic              exc_hit;
   logic              is_eret;
   logic              bad_wen;
   logic [4:0]        code;
   logic [ADDR_W-1:0] bad_addr;
   logic [ADDR_W-1:0] epc;
   logic              take_event;

   always_comb begin
      // NOTE: every output of this block gets a default first. Then no path
      // through the if-chain can leave a value unassigned and infer a latch.
      exc_hit  = 1'b1;
      is_eret  = 1'b0;
      bad_wen  = 1'b0;
      code     = EXC_INT;
      bad_addr = pc_address;
      if (irq) begin
         code = EXC_INT;
      end else if (iaddr_err) begin
         code    = EXC_ADEL;
         bad_wen = 1'b1;
      end else if (syscall) begin
         code = EXC_SYS;
      end else if (break_) begin
         code = EXC_BP;
      end else if (invalid_inst) begin
         code = EXC_RI;
      end else if (priv_inst) begin
         code = EXC_CPU;
      end else if (overflow) begin
         code = EXC_OV;
`ifdef EXC_TRAP_EN
      end else if (trap) begin
         code = EXC_TR;
`endif
      end else if (eret) begin
         exc_hit = 1'b0;
         is_eret = 1'b1;
      end else if (daddr_err) begin
         code     = mem_wen ? EXC_ADES : EXC_ADEL;
         bad_wen  = 1'b1;
         bad_addr = mem_address;
      end else begin
         exc_hit = 1'b0;
      end
   end

   // A delay-slot instruction restarts at its branch, one word earlier.
   assign epc        = in_delay_slot ? (pc_address - ADDR_W'(4)) : pc_address;
   assign take_event = commit_valid & (exc_hit | is_eret);

   // ---------------------------------------------------------------------------
   // Commit FSM with registered outputs
   // ---------------------------------------------------------------------------
   logic              exp_detect_q, exp_en_q, exl_clean_q, bad_wen_q, redirect_valid_q;
   logic [ADDR_W-1:0] epc_q, bad_vaddr_q, redirect_pc_q;
   logic [4:0]        code_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         exp_detect_q     <= 1'b0;
         exp_en_q         <= 1'b0;
         exl_clean_q      <= 1'b0;
         bad_wen_q        <= 1'b0;
         redirect_valid_q <= 1'b0;
         epc_q            <= '0;
         bad_vaddr_q      <= '0;
         code_q           <= '0;
         redirect_pc_q    <= EXC_VECTOR;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         exp_detect_q <= 1'b0;
         exp_en_q     <= 1'b0;
         exl_clean_q  <= 1'b0;
         bad_wen_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (take_event) begin
                  exp_detect_q     <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  state_q          <= S_REDIRECT;
                  if (is_eret) begin
                     exl_clean_q   <= 1'b1;
                     redirect_pc_q <= epc_address;
                  end else begin
                     exp_en_q      <= 1'b1;
                     code_q        <= code;
                     epc_q         <= epc;
                     redirect_pc_q <= EXC_VECTOR;
                     if (bad_wen) begin
                        bad_wen_q   <= 1'b1;
                        bad_vaddr_q <= bad_addr;
                     end
                  end
               end
            end
            S_REDIRECT: begin
               // redirect_valid is always high here, so ready alone completes
               // the handshake.
               if (redirect_ready) begin
                  redirect_valid_q <= 1'b0;
                  state_q          <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign exp_detect            = exp_detect_q;
   assign commit_stall          = (state_q == S_REDIRECT);
   assign cp0_exp_en            = exp_en_q;
   assign cp0_exl_clean         = exl_clean_q;
   assign cp0_exp_epc           = epc_q;
   assign cp0_exp_code          = code_q;
   assign cp0_exp_bad_vaddr     = bad_vaddr_q;
   assign cp0_exp_bad_vaddr_wen = bad_wen_q;
   assign redirect_valid        = redirect_valid_q;
   assign redirect_pc           = redirect_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exception_ctrl
//
// Testbench for exception_ctrl. It runs directed scenarios with hand-computed
// expectations, then a randomized phase. On every cycle, a behavioural model
// checks all DUT outputs. The model keeps a short history of the sampled
// interrupt lines and a record of the outstanding redirect.
// -----------------------------------------------------------------------------
module tb_exception_ctrl;

   localparam int unsigned   ADDR_W    = 32;
   localparam int unsigned   INT_LINES = 8;
   localparam logic [7:0]    EDGE_MASK = 8'h04;
   localparam logic [31:0]   VEC       = 32'hbfc00380;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        commit_valid = 0, iaddr_err = 0, daddr_err = 0, mem_wen = 0;
   logic        invalid_inst = 0, priv_inst = 0, syscall = 0, break_ = 0;
   logic        eret = 0, overflow = 0, in_delay_slot = 0, allow_interrupt = 0;
   logic        redirect_ready = 0;
`ifdef EXC_TRAP_EN
   logic        trap = 0;
`endif
   logic [31:0] pc_address = '0, mem_address = '0, epc_address = '0;
   logic [7:0]  int_mask = '0, int_in = '0;

   logic        exp_detect, commit_stall, cp0_exp_en, cp0_exl_clean;
   logic [31:0] cp0_exp_epc, cp0_exp_bad_vaddr, redirect_pc;
   logic [4:0]  cp0_exp_code;
   logic        cp0_exp_bad_vaddr_wen, redirect_valid;
   logic [7:0]  int_pending;

   exception_ctrl #(
      .ADDR_W(ADDR_W), .INT_LINES(INT_LINES),
      .INT_EDGE_MASK(EDGE_MASK), .EXC_VECTOR(VEC)
   ) dut (
      .clk(clk), .rst(rst), .commit_valid(commit_valid),
      .iaddr_err(iaddr_err), .daddr_err(daddr_err), .mem_wen(mem_wen),
      .invalid_inst(invalid_inst), .priv_inst(priv_inst), .syscall(syscall),
      .break_(break_), .eret(eret), .overflow(overflow),
`ifdef EXC_TRAP_EN
      .trap(trap),
`endif
      .in_delay_slot(in_delay_slot), .pc_address(pc_address),
      .mem_address(mem_address), .epc_address(epc_address),
      .allow_interrupt(allow_interrupt), .int_mask(int_mask), .int_in(int_in),
      .redirect_ready(redirect_ready),
      .exp_detect(exp_detect), .commit_stall(commit_stall),
      .cp0_exp_en(cp0_exp_en), .cp0_exl_clean(cp0_exl_clean),
      .cp0_exp_epc(cp0_exp_epc), .cp0_exp_code(cp0_exp_code),
      .cp0_exp_bad_vaddr(cp0_exp_bad_vaddr),
      .cp0_exp_bad_vaddr_wen(cp0_exp_bad_vaddr_wen),
      .int_pending(int_pending), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   // hist[k] is the int_in value sampled k edges ago. Lines reach the pending
   // view two edges after sampling. An edge line latches when a 0->1 change
   // appears in that delayed view.
   logic [7:0]  hist [0:3];
   logic [7:0]  m_edge;
   bit          m_busy;
   logic        e_detect, e_exp_en, e_exl, e_bad_wen, e_rv;
   logic [31:0] e_epc, e_bad, e_rpc;
   logic [4:0]  e_code;

   function automatic logic [7:0] m_pending();
      return (hist[1] & ~EDGE_MASK) | (m_edge & EDGE_MASK);
   endfunction

   always @(posedge clk) begin
      bit          took_irq, hit, bad_upd, is_eret;
      logic [4:0]  c;
      logic [31:0] ba;
      logic [7:0]  rise;
      if (rst) begin
         for (int i = 0; i < 4; i++) hist[i] = '0;
         m_edge = '0; m_busy = 0;
         e_detect = 0; e_exp_en = 0; e_exl = 0; e_bad_wen = 0; e_rv = 0;
         e_epc = '0; e_bad = '0; e_code = '0; e_rpc = VEC;
      end else begin
         took_irq = 0;
         e_detect = 0; e_exp_en = 0; e_exl = 0; e_bad_wen = 0;
         if (m_busy) begin
            if (redirect_ready) begin
               m_busy = 0;
               e_rv   = 0;
            end
         end else if (commit_valid) begin
            hit = 1; bad_upd = 0; is_eret = 0; c = 5'h00; ba = pc_address;
            if (allow_interrupt && (m_pending() & int_mask) != 0) begin
               c = 5'h00; took_irq = 1;
            end
            else if (iaddr_err)    begin c = 5'h04; bad_upd = 1; end
            else if (syscall)      c = 5'h08;
            else if (break_)       c = 5'h09;
            else if (invalid_inst) c = 5'h0a;
            else if (priv_inst)    c = 5'h0b;
            else if (overflow)     c = 5'h0c;
`ifdef EXC_TRAP_EN
            else if (trap)         c = 5'h0d;
`endif
            else if (eret)         is_eret = 1;
            else if (daddr_err)    begin c = mem_wen ? 5'h05 : 5'h04; bad_upd = 1; ba = mem_address; end
            else hit = 0;
            if (hit) begin
               m_busy = 1; e_rv = 1; e_detect = 1;
               if (is_eret) begin
                  e_exl = 1; e_rpc = epc_address;
               end else begin
                  e_exp_en = 1; e_code = c; e_rpc = VEC;
                  e_epc = in_delay_slot ? pc_address - 32'd4 : pc_address;
                  if (bad_upd) begin e_bad_wen = 1; e_bad = ba; end
               end
            end
         end
         rise   = hist[1] & ~hist[2] & EDGE_MASK;
         m_edge = (took_irq ? 8'h00 : m_edge) | rise;
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = int_in;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("exp_detect",   exp_detect,            e_detect);
         check("commit_stall", commit_stall,          m_busy);
         check("cp0_exp_en",   cp0_exp_en,            e_exp_en);
         check("exl_clean",    cp0_exl_clean,         e_exl);
         check("exp_epc",      cp0_exp_epc,           e_epc);
         check("exp_code",     cp0_exp_code,          e_code);
         check("bad_vaddr",    cp0_exp_bad_vaddr,     e_bad);
         check("bad_wen",      cp0_exp_bad_vaddr_wen, e_bad_wen);
         check("int_pending",  int_pending,           m_pending());
         check("redir_valid",  redirect_valid,        e_rv);
         check("redir_pc",     redirect_pc,           e_rpc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_causes();
      commit_valid = 0; iaddr_err = 0; daddr_err = 0; mem_wen = 0;
      invalid_inst = 0; priv_inst = 0; syscall = 0; break_ = 0;
      eret = 0; overflow = 0; in_delay_slot = 0;
`ifdef EXC_TRAP_EN
      trap = 0;
`endif
   endtask

   task automatic accept();
      redirect_ready = 1;
      tick();
      redirect_ready = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst = 1;
      tick(); tick(); tick();
      chk_en = 1;
      check("rst_rv",      redirect_valid, 1'b0);
      check("rst_rpc",     redirect_pc,    VEC);
      check("rst_pending", int_pending,    8'h00);
      check("rst_stall",   commit_stall,   1'b0);
      rst = 0;
      tick();

      // Syscall from a delay slot, with a held redirect
      commit_valid = 1; syscall = 1; pc_address = 32'h80001000; in_delay_slot = 1;
      tick();
      check("sys_detect", exp_detect,   1'b1);
      check("sys_en",     cp0_exp_en,   1'b1);
      check("sys_code",   cp0_exp_code, 5'h08);
      check("sys_epc",    cp0_exp_epc,  32'h80000ffc);
      check("sys_rv",     redirect_valid, 1'b1);
      check("sys_rpc",    redirect_pc,  32'hbfc00380);
      // The syscall stays presented while stalled and must be ignored.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_detect", exp_detect,     1'b0);
         check("hold_rv",     redirect_valid, 1'b1);
         check("hold_rpc",    redirect_pc,    32'hbfc00380);
         check("hold_stall",  commit_stall,   1'b1);
      end
      clear_causes();
      accept();
      check("acc_rv",    redirect_valid, 1'b0);
      check("acc_stall", commit_stall,   1'b0);

      // Store address error
      commit_valid = 1; daddr_err = 1; mem_wen = 1; mem_address = 32'h13;
      pc_address = 32'h80000100;
      tick();
      check("ades_code", cp0_exp_code,          5'h05);
      check("ades_bad",  cp0_exp_bad_vaddr,     32'h13);
      check("ades_wen",  cp0_exp_bad_vaddr_wen, 1'b1);
      clear_causes();
      accept();
      check("ades_wen_off", cp0_exp_bad_vaddr_wen, 1'b0);

      // Overflow outranks the data address error
      commit_valid = 1; daddr_err = 1; mem_wen = 1; overflow = 1; mem_address = 32'h44;
      tick();
      check("ov_code", cp0_exp_code,          5'h0c);
      check("ov_wen",  cp0_exp_bad_vaddr_wen, 1'b0);
      check("ov_bad",  cp0_exp_bad_vaddr,     32'h13);
      clear_causes();
      accept();

      // ERET
      commit_valid = 1; eret = 1; epc_address = 32'h80002000;
      tick();
      check("eret_exl", cp0_exl_clean, 1'b1);
      check("eret_en",  cp0_exp_en,    1'b0);
      check("eret_rpc", redirect_pc,   32'h80002000);
      clear_causes();
      accept();

      // One-cycle pulse on edge line 2
      int_in = 8'h04;
      tick();
      int_in = 8'h00;
      check("edge_t1", int_pending[2], 1'b0);
      tick();
      check("edge_t2", int_pending[2], 1'b0);
      tick();
      check("edge_t3", int_pending[2], 1'b1);
      tick(); tick();
      check("edge_hold", int_pending[2], 1'b1);
      int_mask = 8'h04; allow_interrupt = 0; commit_valid = 1;
      tick();
      check("irq_blocked", exp_detect, 1'b0);
      allow_interrupt = 1; iaddr_err = 1; pc_address = 32'h80003000;
      tick();
      check("irq_detect",  exp_detect,            1'b1);
      check("irq_code",    cp0_exp_code,          5'h00);
      check("irq_wen",     cp0_exp_bad_vaddr_wen, 1'b0);
      check("irq_cleared", int_pending[2],        1'b0);
      clear_causes();
      allow_interrupt = 0; int_mask = 8'h00;
      accept();

      // Reset while in REDIRECT, with a level line pending
      int_in = 8'h01;
      tick(); tick(); tick();
      check("level_pend", int_pending, 8'h01);
      commit_valid = 1; syscall = 1;
      tick();
      clear_causes();
      check("pre_rst_rv", redirect_valid, 1'b1);
      rst = 1;
      tick();
      check("rst_redir_rv",    redirect_valid, 1'b0);
      check("rst_redir_pend",  int_pending,    8'h00);
      check("rst_redir_stall", commit_stall,   1'b0);
      rst = 0; int_in = 8'h00;
      tick();

      // Randomized phase
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rst            = ($urandom_range(0, 299) == 0);
         commit_valid   = $urandom_range(0, 1);
         iaddr_err      = ($urandom_range(0, 11) == 0);
         daddr_err      = ($urandom_range(0, 5) == 0);
         mem_wen        = $urandom_range(0, 1);
         invalid_inst   = ($urandom_range(0, 11) == 0);
         priv_inst      = ($urandom_range(0, 11) == 0);
         syscall        = ($urandom_range(0, 11) == 0);
         break_         = ($urandom_range(0, 11) == 0);
         eret           = ($urandom_range(0, 7) == 0);
         overflow       = ($urandom_range(0, 11) == 0);
`ifdef EXC_TRAP_EN
         trap           = ($urandom_range(0, 11) == 0);
`endif
         in_delay_slot  = $urandom_range(0, 1);
         pc_address     = $urandom();
         mem_address    = $urandom();
         epc_address    = $urandom();
         allow_interrupt = $urandom_range(0, 1);
         redirect_ready = $urandom_range(0, 1);
         if ($urandom_range(0, 15) == 0) int_in   = 8'($urandom());
         if ($urandom_range(0, 31) == 0) int_mask = 8'($urandom());
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
